// File: rtl/vga_fb_pkg.sv
// ---------------------------------------------------------------------------
// vga_fb_pkg
// Shared types and default geometry for the frame-buffer arbiter slice.
//   state_e      : arbiter FSM state (IDLE / ACTIVE / DONE)
//   DEF_*        : default frame geometry and pixel width
//   FRAME_WORDS  : words in a default-sized frame
//   frame_words(): words in a frame of arbitrary geometry
// ---------------------------------------------------------------------------
package vga_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // after reset, writer traffic only
        ST_ACTIVE = 2'd1,  // prefetching the current frame
        ST_DONE   = 2'd2   // every read of the frame issued, writer traffic only
    } state_e;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_PIXELS = 480;
    localparam int DEF_DATA_W   = 24;
    localparam int FRAME_WORDS  = DEF_H_PIXELS * DEF_V_PIXELS;

    function automatic int frame_words(input int h_pixels, input int v_pixels);
        return h_pixels * v_pixels;
    endfunction

endpackage

// File: rtl/vga_fb_fifo.sv
// ---------------------------------------------------------------------------
// vga_fb_fifo
// Synchronous show-ahead FIFO for display prefetch data. The head entry is
// visible on head_o whenever valid_o is high; pop_i consumes it.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : empty the FIFO; wins over push and pop in the same cycle
//   push_i       : write push_data_i (caller guarantees space via credits)
//   pop_i        : consume head; ignored when empty
//   head_o       : current head entry
//   valid_o      : FIFO non-empty
//   level_o      : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module vga_fb_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              do_pop;
    logic              full;

    assign do_pop  = pop_i && (level_q != '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign valid_o = (level_q != '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // Credits upstream make a push into a full FIFO impossible.
            assert (!(push_i && full && !do_pop));
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; valid_o and level_o gate every
    // read of it, and leaving it unreset lets it map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port frame-buffer RAM between display prefetch (linear
// raster reads into a show-ahead FIFO) and a valid/ready pixel writer.
// Priority each cycle: urgent read > write > opportunistic read > idle.
//   clk, rst             : pixel clock, synchronous active-high reset
//   frame_start          : restart prefetch at address 0, flush FIFO
//   pix_ready/valid/data : display side of the prefetch FIFO
//   wr_valid/addr/data   : writer request; wr_ready = granted this cycle
//   mem_en/we/addr/wdata : RAM strobe and write port
//   mem_rdata            : RAM read data, RD_LAT cycles after a read strobe
//   fifo_level           : FIFO occupancy
//   underrun             : sticky, display asked for data the FIFO lacked
// Optional (macro VGA_FB_ARB_STATS_EN):
//   wr_stall_cnt         : saturating count of blocked writer cycles
// ---------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int H_PIXELS   = DEF_H_PIXELS,
    parameter int V_PIXELS   = DEF_V_PIXELS,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          pix_ready,
    output logic                          pix_valid,
    output logic [DATA_W-1:0]             pix_data,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
`ifdef VGA_FB_ARB_STATS_EN
    ,
    output logic [15:0]                   wr_stall_cnt
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = LVL_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(frame_words(H_PIXELS, V_PIXELS) - 1);
    localparam logic [SUM_W-1:0]  DEPTH_S   = SUM_W'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0]  LOW_WM_S  = SUM_W'(LOW_WM);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [LVL_W-1:0]   inflight_q, inflight_d;
    logic [LVL_W-1:0]   discard_q, discard_d;
    logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;
    logic               underrun_q, underrun_d;

    logic               rd_grant, wr_grant;
    logic               urgent, credit;
    logic               ret, push, pop;
    logic [SUM_W-1:0]   occupancy;

    // Reads still in flight count against FIFO space so the FIFO cannot overflow.
    assign occupancy = SUM_W'(fifo_level) + SUM_W'(inflight_q);
    assign credit    = (state_q == ST_ACTIVE) && (occupancy < DEPTH_S);
    assign urgent    = (state_q == ST_ACTIVE) && (occupancy < LOW_WM_S);

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---- FSM: next state ----
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block can leave it holding (a latch).
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ST_ACTIVE;
        end else if (state_q == ST_ACTIVE && rd_grant && rd_addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
        end
    end

    // ---- FSM: outputs (grant decision) ----
    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        if (urgent)        rd_grant = 1'b1;
        else if (wr_valid) wr_grant = 1'b1;
        else if (credit)   rd_grant = 1'b1;
    end

    assign wr_ready  = wr_grant;
    assign mem_en    = rd_grant | wr_grant;
    assign mem_we    = wr_grant;
    assign mem_addr  = wr_grant ? wr_addr : rd_addr_q;
    assign mem_wdata = wr_grant ? wr_data : '0;

    // ---- Read tracking and FIFO feed ----
    assign ret  = rd_pipe_q[RD_LAT-1];
    assign push = ret && (discard_q == '0) && !frame_start;
    assign pop  = pix_valid && pix_ready;

    always_comb begin
        // Shift in this cycle's read; the oldest bit falls off as it returns.
        rd_pipe_d  = RD_LAT'({rd_pipe_q, rd_grant});
        inflight_d = inflight_q + LVL_W'(rd_grant) - LVL_W'(ret);
        rd_addr_d  = rd_addr_q;
        discard_d  = discard_q;
        underrun_d = underrun_q;

        if (frame_start) begin
            // Everything still outstanding after this cycle, including a read
            // granted right now, belongs to the old frame.
            rd_addr_d = '0;
            discard_d = inflight_d;
        end else begin
            if (rd_grant) rd_addr_d = rd_addr_q + 1'b1;
            if (ret && discard_q != '0) discard_d = discard_q - 1'b1;
        end

        if (pix_ready && !pix_valid && (state_q == ST_ACTIVE || state_q == ST_DONE)) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q  <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_pipe_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_pipe_q  <= rd_pipe_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;

    vga_fb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (frame_start),
        .push_i      (push),
        .push_data_i (mem_rdata),
        .pop_i       (pop),
        .head_o      (pix_data),
        .valid_o     (pix_valid),
        .level_o     (fifo_level)
    );

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (frame_start) begin
            stall_cnt_d = '0;
        end else if (wr_valid && !wr_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign wr_stall_cnt = stall_cnt_q;
`endif

endmodule
